// File: rtl/img_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | img_pkg : shared defaults, FSM state encoding and pixel/marker record       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package img_pkg;

  localparam int c_DATA_WIDTH = 12;
  localparam int c_ADDR_WIDTH = 19;
  localparam int c_IMG_WIDTH  = 400;
  localparam int c_IMG_HEIGHT = 300;
  localparam int c_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_DATA_WIDTH-1:0] data;
    logic                    sof;
    logic                    eol;
    logic                    eof;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_fifo : synchronous first-word-fall-through FIFO of pixel records    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module stream_fifo
  import img_pkg::*;
#(
  parameter  int DEPTH = c_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  pixel_t           i_data,
  input  logic             i_pop,
  output pixel_t           o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  pixel_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/image_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_result_streamer : raster read-back of the processing memory onto a   |
// | valid/ready pixel stream with sof/eol/eof. Option: STREAM_CHKSUM_EN        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module image_result_streamer
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int IMG_WIDTH  = c_IMG_WIDTH,
  parameter int IMG_HEIGHT = c_IMG_HEIGHT,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  start,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  done
`ifdef STREAM_CHKSUM_EN
  ,
  output logic [15:0]           chksum,
  output logic                  chksum_valid
`endif
);

  localparam int c_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int c_COL_W  = $clog2(IMG_WIDTH + 1);
  localparam int c_ROW_W  = $clog2(IMG_HEIGHT + 1);
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_PIXELS - 1);
  localparam logic [c_COL_W-1:0]    c_LAST_COL  = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0]    c_LAST_ROW  = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_CNT_W:0]      c_DEPTH_OCC = (c_CNT_W + 1)'(FIFO_DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic                r_inflight;
  logic                r_tag_sof;
  logic                r_tag_eol;
  logic                r_tag_eof;

  logic                w_start_ok;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_pop;
  logic                w_drained;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [c_CNT_W-1:0]  w_fifo_count;
  logic [c_CNT_W:0]    w_occupancy;
  pixel_t              w_push_pix;
  pixel_t              w_head;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_col_last = (r_col == c_LAST_COL);
  assign w_row_last = (r_row == c_LAST_ROW);

  // The in-flight read already owns a FIFO slot, so it counts toward occupancy.
  assign w_occupancy  = {1'b0, w_fifo_count} + (c_CNT_W + 1)'(r_inflight);
  assign w_issue      = (r_state == READ) && !w_fifo_full && (w_occupancy < c_DEPTH_OCC);
  assign w_last_issue = w_issue && (r_rd_addr == c_LAST_ADDR);

  assign m_valid = !w_fifo_empty;
  assign w_pop   = m_valid && m_ready;

  // Leave DRAIN on the edge that accepts the final pixel so done follows it by one cycle.
  assign w_drained = !r_inflight &&
                     (w_fifo_empty || ((w_fifo_count == c_CNT_W'(1)) && w_pop));

  always_ff @(posedge clk_p) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    r_en         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = READ;
        end
      end
      READ: begin
        r_en = w_issue;
        busy = 1'b1;
        if (w_last_issue) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drained) begin
          w_next_state = FIN;
        end
      end
      FIN: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      r_rd_addr  <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_inflight <= 1'b0;
      r_tag_sof  <= 1'b0;
      r_tag_eol  <= 1'b0;
      r_tag_eof  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_sof <= (r_rd_addr == '0);
        r_tag_eol <= w_col_last;
        r_tag_eof <= w_col_last && w_row_last;
        if (w_last_issue) begin
          r_rd_addr <= '0;
          r_col     <= '0;
          r_row     <= '0;
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + c_ROW_W'(1);
          end else begin
            r_col <= r_col + c_COL_W'(1);
          end
        end
      end else if (w_start_ok) begin
        r_rd_addr <= '0;
        r_col     <= '0;
        r_row     <= '0;
      end
    end
  end

  assign r_addr = r_rd_addr;

  always_comb begin
    w_push_pix      = '0;
    w_push_pix.data = c_DATA_WIDTH'(r_data);
    w_push_pix.sof  = r_tag_sof;
    w_push_pix.eol  = r_tag_eol;
    w_push_pix.eof  = r_tag_eof;
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_p),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_pix),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_data = DATA_WIDTH'(w_head.data);
  assign m_sof  = w_head.sof && m_valid;
  assign m_eol  = w_head.eol && m_valid;
  assign m_eof  = w_head.eof && m_valid;

`ifdef STREAM_CHKSUM_EN
  logic [15:0] r_chksum;

  always_ff @(posedge clk_p) begin
    if (rst) begin
      r_chksum <= '0;
    end else if (w_start_ok) begin
      r_chksum <= '0;
    end else if (w_pop) begin
      r_chksum <= r_chksum + 16'(m_data);
    end
  end

  assign chksum       = r_chksum;
  assign chksum_valid = (r_state == FIN);
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_image_result_streamer : directed/randomized bench for a 4x3 frame        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_image_result_streamer;

  localparam int DW = 12;
  localparam int AW = 19;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 4;
  localparam int N  = W * H;

  logic          clk_p = 1'b0;
  logic          rst;
  logic          start;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof, m_eol, m_eof;
  logic          busy, done;
`ifdef STREAM_CHKSUM_EN
  logic [15:0]   chksum;
  logic          chksum_valid;
`endif

  image_result_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_p   (clk_p),
    .rst     (rst),
    .start   (start),
    .r_en    (r_en),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .m_eof   (m_eof),
    .busy    (busy),
    .done    (done)
`ifdef STREAM_CHKSUM_EN
    ,
    .chksum       (chksum),
    .chksum_valid (chksum_valid)
`endif
  );

  always #5 clk_p = ~clk_p;

  // Processing memory: one cycle read latency, content addr*3.
  always @(posedge clk_p) begin
    if (r_en) r_data <= DW'(r_addr * 3);
  end

  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       exp_idx, rd_exp, n_done, ren_cnt, activity;
  int       first_valid, first_acc, last_acc, start_cyc;
  bit       start_at_done;
  logic     prev_stall;
  logic [DW-1:0] prev_data;
  logic [2:0]    prev_mark;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] ref_data(input int i);
    return DW'(3 * i);
  endfunction

  function automatic logic [2:0] ref_mark(input int i);
    return {i == 0, (i % W) == W - 1, i == N - 1};
  endfunction

  task automatic tick(input logic rdy, input logic st);
    m_ready = rdy;
    start   = st;
    @(negedge clk_p);
    cyc++;
    if (m_valid || busy || r_en) activity++;
    if (r_en) begin
      ren_cnt++;
      chk("rd_addr", 32'(r_addr), rd_exp);
      rd_exp++;
    end
    if (prev_stall) begin
      chk("hold_data", 32'(m_data), 32'(prev_data));
      chk("hold_mark", 32'({m_sof, m_eol, m_eof}), 32'(prev_mark));
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      chk("beat_in_frame", 32'(exp_idx < N), 1);
      chk("pix_data", 32'(m_data), 32'(ref_data(exp_idx)));
      chk("pix_mark", 32'({m_sof, m_eol, m_eof}), 32'(ref_mark(exp_idx)));
      chk("busy_stream", 32'(busy), 1);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      exp_idx++;
    end
    if (done) begin
      n_done++;
      chk("done_beats", exp_idx, N);
      chk("done_lat", cyc, last_acc + 1);
      chk("busy_at_done", 32'(busy), 0);
`ifdef STREAM_CHKSUM_EN
      chk("chksum", 32'(chksum), 198);
      chk("chksum_valid", 32'(chksum_valid), 1);
`endif
      if (start_at_done) start = 1'b1;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_mark  = {m_sof, m_eol, m_eof};
    @(posedge clk_p);
    #1;
  endtask

  function automatic logic rdy_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 1;
      2:       return $urandom_range(0, 3) != 0;
      default: return k >= 19;
    endcase
  endfunction

  // mode 0: always ready, 1: toggling, 2: random, 3: 20-cycle stall then ready
  task automatic run_frame(input int mode, input bit dup_start);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    exp_idx = 0; rd_exp = 0; ren_cnt = 0;
    first_valid = -1; first_acc = -1; last_acc = -10;
    start_cyc = cyc + 1;
    tick(mode != 3, 1'b1);
    while (n_done == d0 && k < 300) begin
      tick(rdy_for(mode, k), dup_start && (k == 4));
      if (mode == 3 && k == 18) begin
        chk("stall_reads", ren_cnt, D);
        chk("stall_valid", 32'(m_valid), 1);
      end
      k++;
    end
    chk("frame_done", n_done, d0 + 1);
    if (mode == 0) begin
      chk("first_valid_lat", first_valid - start_cyc, 3);
      chk("throughput", last_acc - first_acc, N - 1);
    end
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    int d0;
    d0 = n_done;
    activity = 0;
    for (int i = 0; i < ncyc; i++) tick(1'b1, 1'b0);
    chk(tag, activity, 0);
    chk("no_extra_done", n_done, d0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    prev_stall = 1'b0; start_at_done = 1'b0; n_done = 0;
    repeat (3) @(posedge clk_p);
    #1;
    @(negedge clk_p);
    chk("reset_outputs", 32'({r_en, r_addr, m_valid, m_data, m_sof, m_eol, m_eof, busy, done}), 0);
    @(posedge clk_p);
    #1;
    rst = 1'b0;

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(3, 1'b0);
    run_frame(2, 1'b1);
    idle_check("dup_start_ignored", 8);

    start_at_done = 1'b1;
    run_frame(0, 1'b0);
    start_at_done = 1'b0;
    idle_check("start_at_done_ignored", 8);
    run_frame(2, 1'b0);

    // Abort after the fifth accepted pixel.
    exp_idx = 0; rd_exp = 0; first_valid = -1; first_acc = -1;
    tick(1'b1, 1'b1);
    k = 0;
    while (exp_idx < 5 && k < 50) begin
      tick(1'b1, 1'b0);
      k++;
    end
    chk("abort_point", exp_idx, 5);
    rst = 1'b1;
    @(posedge clk_p);
    #1;
    rst = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk_p);
    chk("abort_reset_outputs",
        32'({r_en, r_addr, m_valid, m_data, m_sof, m_eol, m_eof, busy, done}), 0);
    @(posedge clk_p);
    #1;
    idle_check("abort_quiet", 10);
    run_frame(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
